uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's uart_tx. Recovers 8N1 frames (LSB first) from an asynchronous serial line using an oversampling clock. Each byte is delivered with a one-cycle valid strobe. Sits between the board RX pin and the matrix-operand loader.

Parameters:
OVERSAMPLE, 16, clk cycles per bit period; even, >= 4
HALF, OVERSAMPLE/2, derived localparam; mid-bit offset
PARITY_ODD, 0, parity sense when RX_PARITY_EN is defined: 0 = even, 1 = odd

Ports:
clk  input  1  oversampling clock (OVERSAMPLE x baud)
rst  input  1  reset; synchronous, active-high
rx  input  1  asynchronous serial line; idles high
data  output  8  last good received byte; updated only with valid
valid  output  1  one-cycle pulse: data holds a newly received byte
busy  output  1  high while a frame is in progress
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without RX_PARITY_EN)

Behaviour:
- Reset is synchronous and active-high. Every output resets to 0. Sync flops reset to 1. State goes to IDLE. Counters clear. Reset mid-frame aborts the frame with no valid or error pulse.
- rx passes through a 2-flop synchronizer; rx_s is the second flop. All decisions use rx_s.
- T0 is the first clk edge at which the FSM, in IDLE, sees rx_s == 0. This is 2 edges after rx falls.
- States and transitions:
  - IDLE: on rx_s == 0, go to START with cnt = 0. busy = 0.
  - START: cnt counts each clk. At edge T0+HALF, re-sample rx_s. If low, go to DATA with cnt = 0 and bit_idx = 0. If high, treat it as a glitch and return to IDLE with no pulse.
  - DATA: sample rx_s at T0+HALF+(i+1)*OVERSAMPLE into shift bit i, for i = 0..7 (LSB first). After bit 7, go to STOP (or PARITY when the feature is enabled).
  - STOP: sample at T0+HALF+9*OVERSAMPLE.
    - rx_s == 1: data <= shift register and valid = 1 for the next cycle; go to IDLE.
    - rx_s == 0: frame_err = 1 for one cycle; data unchanged; go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents a break or line-low condition from retriggering frames.
- busy = 1 in START, DATA, PARITY, STOP and WAIT_IDLE. busy drops in the same cycle valid rises.
- Back-to-back frames: a new start bit detected in the first IDLE cycle after STOP is accepted. No dead cycles are required beyond the stop sample.
- Pulses never overlap, except parity_err and valid (see below).
- data holds its value between frames.
- cnt width is clog2(OVERSAMPLE). bit_idx is 3 bits and never wraps past 7.

Optional Feature:
Macro RX_PARITY_EN.
- Defined: a PARITY state follows bit 7. The parity bit is sampled at T0+HALF+9*OVERSAMPLE; the stop sample moves to T0+HALF+10*OVERSAMPLE.
- Check: XOR(data bits, parity bit) must equal PARITY_ODD.
- On mismatch with a good stop bit: valid and parity_err pulse together, and data is still updated.
- On a bad stop bit: only frame_err pulses.
- Not defined: 8N1 only, and parity_err is held at 0.

Test Plan:
1. Reset then idle: OVERSAMPLE=16, rst high 3 cycles then rx held 1 for 200 cycles -> data=0x00; valid, busy, frame_err stay 0.
2. Send 0xA5 as 8N1, bit period 16 clk -> valid is one pulse at T0+153 (stop sample at T0+152), data=0xA5, busy high from T0+1 to T0+152, no error.
3. Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses 160 clk apart; data=0x00 then 0xFF.
4. Glitch: rx low for 4 clk then high -> no valid; busy pulses for HALF cycles and then returns to 0; a following 0x3C frame is received correctly.
5. Framing error: send 0x55 with stop bit 0, then hold rx low 40 clk -> one frame_err pulse, no valid, data keeps its previous value, busy stays 1 until rx returns high.
6. Reset mid-frame: assert rst during bit 4 of 0x81, then send 0x42 -> no pulse for the aborted frame; data=0x42 with one valid. With RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> valid and parity_err both pulse, data=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1 frames (LSB first) from an oversampled serial line.
// Define RX_PARITY_EN to expect a parity bit between data bit 7 and the stop bit.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int HALF  = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic             sync1_q, rx_s_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      // The start bit is re-checked at mid-bit so short line glitches are dropped.
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
`ifdef RX_PARITY_EN
            parity_err_d = ((^shift_q) ^ par_bit_q) != PARITY_ODD;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A held-low line (break) must go high before another start bit is accepted.
      S_WAIT_IDLE: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD;
  assign parity_err        = 1'b0;
`endif

endmodule
